// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the DE->EX->MEM->WB hazard controller: FSM states, forwarding
// selects and the shadow-pipeline slot record.
package pipe_hazard_ctrl_pkg;

  // Slot rd is stored at a fixed width so the struct can live here; REG_AW must not exceed it.
  localparam int unsigned RegAwMax = 8;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    logic                valid;
    logic [RegAwMax-1:0] rd;
    logic                reg_write;
    logic                mem_read;
  } slot_s;

  localparam slot_s SlotBubble = '0;

  // x0 is hardwired zero, so it never produces a value worth forwarding or stalling on.
  function automatic logic slot_produces(input slot_s s, input logic [RegAwMax-1:0] r);
    return s.valid & s.reg_write & (s.rd != '0) & (s.rd == r);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Load-use stall, branch flush sequencing and registered forwarding selects for the
// instruction entering EX, tracked with a 3-slot shadow of the downstream stages.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned REG_AW       = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de_valid,
  input  logic [REG_AW-1:0] de_rs1,
  input  logic [REG_AW-1:0] de_rs2,
  input  logic              de_rs1_used,
  input  logic              de_rs2_used,
  input  logic [REG_AW-1:0] de_rd,
  input  logic              de_reg_write,
  input  logic              de_mem_read,
  input  logic              branch_taken,
  output logic              stall_o,
  output logic              flush_o,
  output logic [1:0]        fwd_rs1_sel,
  output logic [1:0]        fwd_rs2_sel,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

  hz_state_e             state_q;
  logic [2:0]            flush_cnt_q;
  slot_s                 ex_q, mem_q, wb_q, de_slot;
  logic [RegAwMax-1:0]   rs1_x, rs2_x;
  logic                  issue, hazard;
  fwd_sel_e              sel1_d, sel2_d;

  assign rs1_x = RegAwMax'(de_rs1);
  assign rs2_x = RegAwMax'(de_rs2);

  // A load in EX is never a forwarding source; the load-use stall lets it reach MEM first.
  function automatic fwd_sel_e pick_fwd(input logic used, input logic [RegAwMax-1:0] rs,
                                        input slot_s ex, input slot_s mem);
    if (!used) begin
      return FWD_RF;
    end else if (slot_produces(ex, rs) && !ex.mem_read) begin
      return FWD_MEM;
    end else if (slot_produces(mem, rs)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

  always_comb begin
    issue  = de_valid & ~stall_o & ~flush_o;
    hazard = de_valid &
             ((de_rs1_used & slot_produces(ex_q, rs1_x) & ex_q.mem_read) |
              (de_rs2_used & slot_produces(ex_q, rs2_x) & ex_q.mem_read));
    de_slot = '{valid: 1'b1, rd: RegAwMax'(de_rd), reg_write: de_reg_write,
                mem_read: de_mem_read};
    sel1_d  = issue ? pick_fwd(de_rs1_used, rs1_x, ex_q, mem_q) : FWD_RF;
    sel2_d  = issue ? pick_fwd(de_rs2_used, rs2_x, ex_q, mem_q) : FWD_RF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q        <= SlotBubble;
      mem_q       <= SlotBubble;
      wb_q        <= SlotBubble;
      fwd_rs1_sel <= FWD_RF;
      fwd_rs2_sel <= FWD_RF;
    end else begin
      ex_q        <= issue ? de_slot : SlotBubble;
      mem_q       <= ex_q;
      wb_q        <= mem_q;
      fwd_rs1_sel <= sel1_d;
      fwd_rs2_sel <= sel2_d;
    end
  end

  // Flush wins over stall in every state; a branch during FLUSH restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      stall_o     <= 1'b0;
      flush_o     <= 1'b0;
    end else begin
      stall_o <= 1'b0;
      flush_o <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (branch_taken) begin
            state_q     <= FLUSH;
            flush_cnt_q <= FlushLoad;
            flush_o     <= 1'b1;
          end else if (hazard) begin
            state_q <= STALL;
            stall_o <= 1'b1;
          end
        end
        STALL: begin
          if (branch_taken) begin
            state_q     <= FLUSH;
            flush_cnt_q <= FlushLoad;
            flush_o     <= 1'b1;
          end else begin
            state_q <= RUN;
          end
        end
        FLUSH: begin
          if (branch_taken) begin
            flush_cnt_q <= FlushLoad;
            flush_o     <= 1'b1;
          end else if (flush_cnt_q == 3'd0) begin
            state_q <= RUN;
          end else begin
            flush_cnt_q <= flush_cnt_q - 3'd1;
            flush_o     <= 1'b1;
          end
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (stall_o),
    .count(stall_count)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (branch_taken),
    .count(flush_count)
  );

  // The WB slot and MEM load flag complete the shadow pipeline but feed no decision.
  logic unused_slots;
  assign unused_slots = ^{wb_q, mem_q.mem_read};

endmodule
